parking_ctrl_v2: RTL and testbench

Second-generation two-zone parking controller: counts university-reserved and general cars and tracks per-zone capacity and vacancy. It also shifts capacity between zones by time of day. All widths, capacities, the shift schedule and the hour length are parameters. An internal hour-tick generator drives the schedule. Sits between the gate sensors and the occupancy display/barrier logic.

---
 rtl/parking_pkg.sv | 27 ++
 rtl/parking_ctrl_v2_hour_tick_gen.sv | 44 ++++
 rtl/parking_ctrl_v2.sv | 143 ++++++++++++++
 tb/tb_parking_ctrl_v2.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and helpers for the two-zone parking controller.
// Hour width, day length, zone encoding and unsigned min/max.
package parking_pkg;

  localparam int HOUR_W        = 5;
  localparam int HOURS_PER_DAY = 24;

  typedef enum logic {
    ZONE_GEN = 1'b0,
    ZONE_UNI = 1'b1
  } zone_e;

  function automatic int unsigned umin(
    input int unsigned a,
    input int unsigned b
  );
    return (a < b) ? a : b;
  endfunction

  function automatic int unsigned umax(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/parking_ctrl_v2_hour_tick_gen.sv
// Simulated clock: emits a one-cycle tick every CYCLES_PER_HOUR clocks
// and keeps the hour of day, wrapping 23 -> 0.
module hour_tick_gen
  import parking_pkg::*;
#(
  parameter int CYCLES_PER_HOUR = 5,
  parameter int START_HOUR      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              tick,
  output logic [HOUR_W-1:0] hour_of_day
);

  localparam int CW =
    (CYCLES_PER_HOUR > 1) ? $clog2(CYCLES_PER_HOUR) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_HOUR - 1);
  localparam logic [HOUR_W-1:0] H_LAST = HOUR_W'(HOURS_PER_DAY - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [HOUR_W-1:0] hour_q, hour_d;

  assign tick        = (cnt_q == LAST);
  assign hour_of_day = hour_q;

  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + CW'(1);
    hour_d = hour_q;
    if (tick) begin
      hour_d = (hour_q == H_LAST) ? '0 : hour_q + HOUR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      hour_q <= HOUR_W'(START_HOUR);
    end else begin
      cnt_q  <= cnt_d;
      hour_q <= hour_d;
    end
  end

endmodule

// File: rtl/parking_ctrl_v2.sv
// Two-zone parking controller: uni/general car counts, vacancy and
// a time-of-day schedule that moves capacity between the zones.
module parking_ctrl_v2
  import parking_pkg::*;
#(
  parameter int CNT_W           = 11,
  parameter int TOTAL_CAP       = 700,
  parameter int UNI_CAP_INIT    = 500,
  parameter int UNI_CAP_MIN     = 200,
  parameter int SHIFT_STEP      = 50,
  parameter int CYCLES_PER_HOUR = 5,
  parameter int START_HOUR      = 8,
  parameter int SHIFT_FIRST     = 14,
  parameter int SHIFT_LAST      = 15,
  parameter int RECLAIM_HOUR    = 16,
  parameter int OPEN_HOUR       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              car_entered,
  input  logic              is_uni_car_entered,
  input  logic              car_exited,
  input  logic              is_uni_car_exited,
  output logic [CNT_W-1:0]  uni_parked_car,
  output logic [CNT_W-1:0]  parked_car,
  output logic [CNT_W-1:0]  uni_capacity,
  output logic [CNT_W-1:0]  capacity,
  output logic [CNT_W-1:0]  uni_vacated_space,
  output logic [CNT_W-1:0]  vacated_space,
  output logic              uni_is_vacated_space,
  output logic              is_vacated_space,
  output logic [4:0]        hour_of_day,
  output logic              entry_ok,
  output logic              entry_rejected,
  output logic              exit_error
);

  localparam logic [CNT_W-1:0] TOT = CNT_W'(TOTAL_CAP);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [HOUR_W-1:0] H_LAST = HOUR_W'(HOURS_PER_DAY - 1);

  logic              tick;
  logic [HOUR_W-1:0] hour_q, hour_n;

  logic [CNT_W-1:0] upark_q, upark_d;
  logic [CNT_W-1:0] gpark_q, gpark_d;
  logic [CNT_W-1:0] ucap_q, ucap_d;
  logic             eok_q, erej_q, xerr_q;

  zone_e            ent_zone, ext_zone;
  logic [CNT_W-1:0] ent_vac, ext_cnt, uvac_ev;
  logic             ent_acc, ext_acc, in_shift;
  int unsigned      tmp;

  hour_tick_gen #(
    .CYCLES_PER_HOUR (CYCLES_PER_HOUR),
    .START_HOUR      (START_HOUR)
  ) u_hour (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .hour_of_day (hour_q)
  );

  assign hour_of_day = hour_q;
  assign hour_n = (hour_q == H_LAST) ? '0 : hour_q + HOUR_W'(1);
  assign in_shift = (32'(hour_n) >= 32'(SHIFT_FIRST))
                 && (32'(hour_n) <= 32'(SHIFT_LAST));

  assign uni_parked_car       = upark_q;
  assign parked_car           = gpark_q;
  assign uni_capacity         = ucap_q;
  assign capacity             = TOT - ucap_q;
  assign uni_vacated_space    = ucap_q - upark_q;
  assign vacated_space        = capacity - gpark_q;
  assign uni_is_vacated_space = (uni_vacated_space != '0);
  assign is_vacated_space     = (vacated_space != '0);
  assign entry_ok             = eok_q;
  assign entry_rejected       = erej_q;
  assign exit_error           = xerr_q;

  always_comb begin
    ent_zone = zone_e'(is_uni_car_entered);
    ext_zone = zone_e'(is_uni_car_exited);
    ent_vac  = (ent_zone == ZONE_UNI) ? uni_vacated_space
                                      : vacated_space;
    ext_cnt  = (ext_zone == ZONE_UNI) ? upark_q : gpark_q;
    ent_acc  = car_entered && (ent_vac != '0);
    ext_acc  = car_exited && (ext_cnt != '0);

    upark_d = upark_q;
    gpark_d = gpark_q;
    if (ent_acc) begin
      if (ent_zone == ZONE_UNI) upark_d = upark_d + ONE;
      else                      gpark_d = gpark_d + ONE;
    end
    if (ext_acc) begin
      if (ext_zone == ZONE_UNI) upark_d = upark_d - ONE;
      else                      gpark_d = gpark_d - ONE;
    end

    // Schedule acts on the post-event counts and the new hour.
    ucap_d  = ucap_q;
    uvac_ev = ucap_q - upark_d;
    tmp     = 0;
    if (tick) begin
      priority case (1'b1)
        (32'(hour_n) == 32'(RECLAIM_HOUR)): begin
          tmp    = umax(32'(upark_d), UNI_CAP_MIN);
          ucap_d = CNT_W'(umin(tmp, 32'(TOT - gpark_d)));
        end
        (32'(hour_n) == 32'(OPEN_HOUR)): begin
          tmp    = umin(UNI_CAP_INIT, 32'(TOT - gpark_d));
          ucap_d = CNT_W'(umax(tmp, 32'(upark_d)));
        end
        in_shift: begin
          tmp    = umin(32'(uvac_ev), SHIFT_STEP);
          ucap_d = ucap_q - CNT_W'(tmp);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upark_q <= '0;
      gpark_q <= '0;
      ucap_q  <= CNT_W'(UNI_CAP_INIT);
      eok_q   <= 1'b0;
      erej_q  <= 1'b0;
      xerr_q  <= 1'b0;
    end else begin
      upark_q <= upark_d;
      gpark_q <= gpark_d;
      ucap_q  <= ucap_d;
      eok_q   <= ent_acc;
      erej_q  <= car_entered && !ent_acc;
      xerr_q  <= car_exited && !ext_acc;
    end
  end

endmodule

// File: tb/tb_parking_ctrl_v2.sv
// Randomized and directed bench for parking_ctrl_v2 against a
// behavioural occupancy/schedule model.
module tb_parking_ctrl_v2;

  localparam int TOTAL = 700;
  localparam int CPH   = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        car_entered = 1'b0;
  logic        is_uni_car_entered = 1'b0;
  logic        car_exited = 1'b0;
  logic        is_uni_car_exited = 1'b0;
  logic [10:0] uni_parked_car, parked_car;
  logic [10:0] uni_capacity, capacity;
  logic [10:0] uni_vacated_space, vacated_space;
  logic        uni_is_vacated_space, is_vacated_space;
  logic [4:0]  hour_of_day;
  logic        entry_ok, entry_rejected, exit_error;

  int n_chk = 0;
  int n_fail = 0;

  int m_up, m_gp, m_ucap, m_hour, m_cyc;
  bit m_eok, m_erej, m_xerr;

  parking_ctrl_v2 dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .car_entered          (car_entered),
    .is_uni_car_entered   (is_uni_car_entered),
    .car_exited           (car_exited),
    .is_uni_car_exited    (is_uni_car_exited),
    .uni_parked_car       (uni_parked_car),
    .parked_car           (parked_car),
    .uni_capacity         (uni_capacity),
    .capacity             (capacity),
    .uni_vacated_space    (uni_vacated_space),
    .vacated_space        (vacated_space),
    .uni_is_vacated_space (uni_is_vacated_space),
    .is_vacated_space     (is_vacated_space),
    .hour_of_day          (hour_of_day),
    .entry_ok             (entry_ok),
    .entry_rejected       (entry_rejected),
    .exit_error           (exit_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void m_reset();
    m_up = 0; m_gp = 0; m_ucap = 500;
    m_hour = 8; m_cyc = 0;
    m_eok = 0; m_erej = 0; m_xerr = 0;
  endfunction

  // One clock of the parking lot as described in plain terms.
  function automatic void m_edge(input bit ce, input bit ceu,
                                 input bit cx, input bit cxu);
    int uvac = m_ucap - m_up;
    int gvac = (TOTAL - m_ucap) - m_gp;
    int up = m_up;
    int gp = m_gp;
    m_eok = 0; m_erej = 0; m_xerr = 0;
    if (ce) begin
      if ((ceu ? uvac : gvac) > 0) begin
        m_eok = 1;
        if (ceu) up++; else gp++;
      end else m_erej = 1;
    end
    if (cx) begin
      if ((cxu ? m_up : m_gp) > 0) begin
        if (cxu) up--; else gp--;
      end else m_xerr = 1;
    end
    m_up = up; m_gp = gp;
    m_cyc++;
    if (m_cyc % CPH == 0) begin
      m_hour = (m_hour + 1) % 24;
      if (m_hour == 16) begin
        m_ucap = imin(imax(m_up, 200), TOTAL - m_gp);
      end else if (m_hour == 8) begin
        m_ucap = imax(imin(500, TOTAL - m_gp), m_up);
      end else if (m_hour == 14 || m_hour == 15) begin
        m_ucap = m_ucap - imin(m_ucap - m_up, 50);
      end
    end
  endfunction

  task automatic check_all();
    chk("uni_parked", int'(uni_parked_car), m_up);
    chk("parked", int'(parked_car), m_gp);
    chk("uni_cap", int'(uni_capacity), m_ucap);
    chk("cap", int'(capacity), TOTAL - m_ucap);
    chk("uni_vac", int'(uni_vacated_space), m_ucap - m_up);
    chk("vac", int'(vacated_space), TOTAL - m_ucap - m_gp);
    chk("uni_flag", int'(uni_is_vacated_space),
        int'(m_ucap - m_up != 0));
    chk("gen_flag", int'(is_vacated_space),
        int'(TOTAL - m_ucap - m_gp != 0));
    chk("hour", int'(hour_of_day), m_hour);
    chk("entry_ok", int'(entry_ok), int'(m_eok));
    chk("entry_rej", int'(entry_rejected), int'(m_erej));
    chk("exit_err", int'(exit_error), int'(m_xerr));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit ce, input bit ceu,
                      input bit cx, input bit cxu);
    car_entered = ce; is_uni_car_entered = ceu;
    car_exited = cx;  is_uni_car_exited = cxu;
    @(posedge clk);
    m_edge(ce, ceu, cx, cxu);
    @(negedge clk);
    car_entered = 0; car_exited = 0;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_to_hour(input int h, input string tag);
    int n = 0;
    do begin
      step(0, 0, 0, 0);
      n++;
    end while (!(m_hour == h && m_cyc % CPH == 0) && n < 200);
    if (n >= 200) chk({tag, "_timeout"}, n, 0);
  endtask

  initial begin
    int n;
    int prev;
    m_reset();
    #12;
    check_all();
    chk("rst_uni_vac", int'(uni_vacated_space), 500);
    chk("rst_vac", int'(vacated_space), 200);
    chk("rst_hour", int'(hour_of_day), 8);
    @(negedge clk);
    rst_n = 1'b1;

    // exit on empty uni zone
    step(0, 0, 1, 1);
    chk("exit_empty_err", int'(exit_error), 1);
    chk("exit_empty_cnt", int'(uni_parked_car), 0);

    // fill general zone until full, then overflow entries
    n = 0;
    while (TOTAL - m_ucap - m_gp > 0 && n < 3000) begin
      step(1, 0, 0, 0);
      n++;
    end
    if (n >= 3000) chk("gen_fill_timeout", n, 0);
    chk("gen_full_flag", int'(is_vacated_space), 0);
    step(1, 0, 0, 0);
    chk("gen_over_rej", int'(entry_rejected), 1);
    if (TOTAL - m_ucap - m_gp == 0) begin
      prev = m_gp;
      step(1, 0, 1, 0);
      chk("full_ent_exit_rej", int'(entry_rejected), 1);
      chk("full_ent_exit_cnt", int'(parked_car), prev - 1);
    end

    // uni zone to 480, then the hour-14/15 shifts
    do_reset();
    n = 0;
    while (m_up < 480 && n < 3000) begin
      step(1, 1, 0, 0);
      n++;
    end
    if (n >= 3000) chk("uni_fill_timeout", n, 0);
    idle_to_hour(14, "h14");
    chk("h14_uni_cap", int'(uni_capacity), m_ucap);
    idle_to_hour(15, "h15");
    chk("h15_uni_cap", int'(uni_capacity), m_ucap);

    // 120 uni + 30 general, reclaim at hour 16
    do_reset();
    for (int i = 0; i < 120; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 30; i++) step(1, 0, 0, 0);
    idle_to_hour(16, "h16");
    chk("h16_uni_cap", int'(uni_capacity), 200);
    chk("h16_cap", int'(capacity), 500);
    chk("h16_uni_vac", int'(uni_vacated_space), 80);

    // general to 300, restore at next hour 8
    n = 0;
    while (m_gp < 300 && n < 3000) begin
      step(1, 0, 0, 0);
      n++;
    end
    if (n >= 3000) chk("gen300_timeout", n, 0);
    idle_to_hour(8, "h8");
    chk("h8_uni_cap", int'(uni_capacity), 400);

    // asynchronous reset mid-hour
    step(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all();
    chk("async_rst_cap", int'(uni_capacity), 500);
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
